// File: rtl/gray_frame_streamer.sv
// Frame source: reads a WxH 8-bit frame from sync-read RAM in raster order, adds HBLANK gaps and pad rows.
// Pixels appear 2 cycles after issue; hold only throttles new issues, nothing downstream can stall.
module gray_frame_streamer #(
  parameter int          IMAGE_WIDTH  = 320,
  parameter int          IMAGE_HEIGHT = 240,
  parameter int          HBLANK       = 4,
  parameter int          PAD_ROWS     = 1,
  parameter logic [7:0]  PAD_VALUE    = 8'd0,
  parameter int          ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              gray_valid,
  output logic [7:0]        gray,
  output logic              sof,
  output logic              eol,
  output logic              busy,
  output logic              done
);
  localparam int TOTAL_ROWS = IMAGE_HEIGHT + PAD_ROWS;
  localparam int COL_W      = $clog2(IMAGE_WIDTH);
  localparam int ROW_W      = $clog2(TOTAL_ROWS + 1);
  localparam int BLK_W      = $clog2(HBLANK + 2);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_IMG  = ROW_W'(IMAGE_HEIGHT);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_BLANK, S_PAD, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BLK_W-1:0]  blk_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue;
  logic              last_col;
  logic              last_row;
  logic              next_is_pad;

  // Stage 1 of the pixel pipe: lines up with mem_rdata arriving.
  logic s1_vld, s1_pad, s1_sof, s1_eol;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    mem_rd_en   = 1'b0;
    last_col    = (col == COL_LAST);
    last_row    = (row == ROW_LAST);
    next_is_pad = ((row + ROW_W'(1)) >= ROW_IMG);
    case (state)
      S_IDLE: if (start) state_nxt = S_READ;
      S_READ, S_PAD: begin
        issue     = !hold;
        mem_rd_en = (state == S_READ) && !hold;
        if (issue && last_col) begin
          if (last_row)         state_nxt = S_DRAIN;
          else if (HBLANK > 0)  state_nxt = S_BLANK;
          else if (next_is_pad) state_nxt = S_PAD;
          else                  state_nxt = S_READ;
        end
      end
      // row has already advanced to the upcoming row while blanking
      S_BLANK: if (blk_cnt == BLK_LAST) state_nxt = (row >= ROW_IMG) ? S_PAD : S_READ;
      S_DRAIN: if (!s1_vld) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr = rd_addr;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      blk_cnt    <= '0;
      rd_addr    <= '0;
      s1_vld     <= 1'b0;
      s1_pad     <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eol     <= 1'b0;
      gray_valid <= 1'b0;
      gray       <= 8'd0;
      sof        <= 1'b0;
      eol        <= 1'b0;
    end else begin
      // Image rows are contiguous, so the read address is just a running pointer.
      if (state == S_IDLE && start) begin
        rd_addr <= base_addr;
        col     <= '0;
        row     <= '0;
      end else begin
        if (mem_rd_en) rd_addr <= rd_addr + ADDR_W'(1);
        if (issue) begin
          if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end
      blk_cnt <= (state == S_BLANK) ? blk_cnt + BLK_W'(1) : '0;

      s1_vld <= issue;
      s1_pad <= (state == S_PAD);
      s1_sof <= issue && (row == '0) && (col == '0);
      s1_eol <= issue && last_col;

      gray_valid <= s1_vld;
      sof        <= s1_vld && s1_sof;
      eol        <= s1_vld && s1_eol;
      if (s1_vld) gray <= s1_pad ? PAD_VALUE : mem_rdata;
    end
  end
endmodule

// File: tb/tb_gray_frame_streamer.sv
// Bench: two streamers (blanking+pad, and back-to-back without pad) driven in turn and checked against
// an expected-frame model built from raster order, row gaps and pad rows.
module tb_gray_frame_streamer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start0 = 1'b0, start1 = 1'b0, hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  bit            sel = 1'b0;

  logic          rd0, rd1, gv0, gv1, sof0, sof1, eol0, eol1, busy0, busy1, done0, done1;
  logic [AW-1:0] ad0, ad1;
  logic [7:0]    rq0 = 8'd0, rq1 = 8'd0, g0, g1;
  logic [7:0]    ram [0:255];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);

  always @(posedge clk) if (rd0) rq0 <= ram[ad0[7:0]];
  always @(posedge clk) if (rd1) rq1 <= ram[ad1[7:0]];

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(2), .PAD_ROWS(1),
                        .PAD_VALUE(8'd0), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr), .hold(hold),
    .mem_rd_en(rd0), .mem_addr(ad0), .mem_rdata(rq0), .gray_valid(gv0), .gray(g0),
    .sof(sof0), .eol(eol0), .busy(busy0), .done(done0));

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(0), .PAD_ROWS(0),
                        .PAD_VALUE(8'd0), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .hold(hold),
    .mem_rd_en(rd1), .mem_addr(ad1), .mem_rdata(rq1), .gray_valid(gv1), .gray(g1),
    .sof(sof1), .eol(eol1), .busy(busy1), .done(done1));

  logic          m_rd, m_gv, m_sof, m_eol, m_busy, m_done;
  logic [AW-1:0] m_ad;
  logic [7:0]    m_g;
  always_comb begin
    if (sel) begin
      m_rd = rd1; m_ad = ad1; m_gv = gv1; m_g = g1; m_sof = sof1; m_eol = eol1;
      m_busy = busy1; m_done = done1;
    end else begin
      m_rd = rd0; m_ad = ad0; m_gv = gv0; m_g = g0; m_sof = sof0; m_eol = eol0;
      m_busy = busy0; m_done = done0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pv_q[$], pc_q[$], ps_q[$], pe_q[$], ra_q[$], rc_q[$], dn_q[$];
  int stray = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (m_gv) begin
      pv_q.push_back(int'(m_g)); pc_q.push_back(cyc);
      ps_q.push_back(int'(m_sof)); pe_q.push_back(int'(m_eol));
    end else if (m_sof || m_eol) begin
      stray++;
    end
    if (m_rd) begin ra_q.push_back(int'(m_ad)); rc_q.push_back(cyc); end
    if (m_done) dn_q.push_back(cyc);
    if (m_busy) busy_cnt++;
  end

  int errs = 0, checks = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    pv_q.delete(); pc_q.delete(); ps_q.delete(); pe_q.delete();
    ra_q.delete(); rc_q.delete(); dn_q.delete();
    stray = 0; busy_cnt = 0;
  endtask

  // hmode: 0 = no hold, 1 = 3-cycle hold early in row 1, 2 = random hold
  task automatic run_frame(input int b, input int hmode, input bit restart, input int hb, input int pr);
    int s, n, tot, ev;
    clear_log();
    tot = W * (H + pr);
    base_addr = AW'(b);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    s = cyc;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    n = 0;
    while (dn_q.size() == 0 && n < 300) begin
      hold = (hmode == 1 && n >= 7 && n <= 9) || (hmode == 2 && $urandom_range(0, 3) == 0);
      if (restart && n == 8) begin
        base_addr = AW'(50);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      tick();
      n++;
    end
    hold = 1'b0; start0 = 1'b0; start1 = 1'b0;
    if (n >= 300) check_eq("done_timeout", n, 0);
    repeat (20) tick();

    check_eq("pix_count", pv_q.size(), tot);
    for (int i = 0; i < tot && i < pv_q.size(); i++) begin
      ev = (i < W * H) ? ((b + i + 1) & 255) : 0;
      check_eq("pix_val", pv_q[i], ev);
      check_eq("pix_sof", ps_q[i], (i == 0) ? 1 : 0);
      check_eq("pix_eol", pe_q[i], ((i % W) == W - 1) ? 1 : 0);
    end
    check_eq("rd_count", ra_q.size(), W * H);
    for (int i = 0; i < W * H && i < ra_q.size(); i++) check_eq("rd_addr", ra_q[i], b + i);
    check_eq("stray_flags", stray, 0);
    check_eq("done_count", dn_q.size(), 1);
    if (dn_q.size() == 1 && pc_q.size() > 0) begin
      check_eq("done_after_last", dn_q[0], pc_q[pc_q.size() - 1] + 1);
      check_eq("busy_cycles", busy_cnt, dn_q[0] - s);
    end
    if (hmode == 0) begin
      if (rc_q.size() > 0) check_eq("first_rd_cyc", rc_q[0], s + 1);
      for (int i = 0; i < pc_q.size() && i < tot; i++)
        check_eq("pix_cyc", pc_q[i], s + 3 + i + (i / W) * hb);
    end
    if (hmode == 1 && pc_q.size() > 5) check_eq("hold_gap", pc_q[5] - pc_q[4], 4);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_gv", int'(gv0), 0);
    check_eq("rst_rd", int'(rd0), 0);
    check_eq("rst_busy", int'(busy0), 0);
    check_eq("rst_done", int'(done0), 0);
    check_eq("rst_gray", int'(g0), 0);
    check_eq("rst_gv1", int'(gv1), 0);
    rst = 1'b0;
    tick();

    sel = 1'b0;
    run_frame(0, 0, 1'b0, 2, 1);
    run_frame(0, 1, 1'b1, 2, 1);
    run_frame(100, 0, 1'b0, 2, 1);

    // abort mid row 1
    clear_log();
    base_addr = '0;
    start0 = 1'b1;
    s = cyc;
    tick();
    start0 = 1'b0;
    repeat (8) tick();
    check_eq("pre_rst_gv", int'(gv0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_gv", int'(gv0), 0);
    check_eq("abort_gray", int'(g0), 0);
    check_eq("abort_rd", int'(rd0), 0);
    check_eq("abort_busy", int'(busy0), 0);
    check_eq("abort_done", int'(done0), 0);
    check_eq("abort_sof_eol", int'(sof0 | eol0), 0);
    clear_log();
    repeat (30) tick();
    check_eq("abort_no_done", dn_q.size(), 0);
    check_eq("abort_no_pix", pv_q.size(), 0);
    check_eq("abort_no_rd", ra_q.size(), 0);
    run_frame(0, 0, 1'b0, 2, 1);

    sel = 1'b1;
    tick();
    run_frame(0, 0, 1'b0, 0, 0);
    run_frame($urandom_range(0, 200), 2, 1'b0, 0, 0);

    sel = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) run_frame($urandom_range(0, 200), 2, 1'b0, 2, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
